spi_job_sequencer: RTL and testbench

- Autonomous APB master that drives a complete SPI transfer on the apb_spi_master register block.
- Accepts one job descriptor, programs CMD/ADDR/LEN/DUMMY, starts the transfer and streams TX words in or RX words out.
- Polls STATUS until the SPI controller returns to idle, then pulses done.
- Sits between a boot/DMA client and the SPI master APB port, so clients never handle register-level sequencing.

---
 rtl/spi_job_seq_pkg.sv | 83 ++++++++
 rtl/spi_job_apb_port.sv | 76 +++++++
 rtl/spi_job_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_job_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_job_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_job_seq_pkg
// Purpose  : Shared definitions for the SPI job sequencer: SPI master
//            register offsets, STATUS bit positions, job descriptor type,
//            sequencer state encoding and register word builders.
// Revision : 1.0 - initial release
// ============================================================================
package spi_job_seq_pkg;

  // Register offsets relative to the SPI master base address
  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_CMD    = 8'h08;
  localparam logic [7:0] REG_ADDR   = 8'h0C;
  localparam logic [7:0] REG_LEN    = 8'h10;
  localparam logic [7:0] REG_DUMMY  = 8'h14;
  localparam logic [7:0] REG_TXFIFO = 8'h18;
  localparam logic [7:0] REG_RXFIFO = 8'h20;

  // STATUS write fields
  localparam int ST_RD     = 0;
  localparam int ST_WR     = 1;
  localparam int ST_QRD    = 2;
  localparam int ST_QWR    = 3;
  localparam int ST_SWRST  = 4;
  localparam int ST_CS_LSB = 8;
  // STATUS read fields
  localparam int ST_IDLE    = 0;
  localparam int ST_ERX_LSB = 16;
  localparam int ST_ETX_LSB = 24;

  typedef struct packed {
    logic [31:0] cmd;
    logic [5:0]  cmd_len;
    logic [31:0] addr;
    logic [5:0]  addr_len;
    logic [15:0] dummy;
    logic [15:0] data_len;
    logic        wr;
    logic        quad;
    logic [1:0]  cs;
  } job_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_W_CMD     = 4'd1,
    S_W_ADDR    = 4'd2,
    S_W_LEN     = 4'd3,
    S_W_DUM     = 4'd4,
    S_W_START   = 4'd5,
    S_WR_POLL   = 4'd6,
    S_WR_DATA   = 4'd7,
    S_RD_POLL   = 4'd8,
    S_RD_DATA   = 4'd9,
    S_RX_HOLD   = 4'd10,
    S_POLL_IDLE = 4'd11,
    S_DONE      = 4'd12
  } state_t;

  function automatic logic [31:0] len_word(input job_t j);
    return {j.data_len, 2'b00, j.addr_len, 2'b00, j.cmd_len};
  endfunction

  // The dummy count only lands in the field for the active direction
  function automatic logic [31:0] dummy_word(input job_t j);
    return j.wr ? {j.dummy, 16'h0000} : {16'h0000, j.dummy};
  endfunction

  // Quad mode selects qrd/qwr instead of rd/wr; cs is one-hot
  function automatic logic [31:0] status_start_word(input job_t j);
    logic [31:0] w;
    w = '0;
    w[ST_CS_LSB +: 4] = 4'b0001 << j.cs;
    w[ST_SWRST]       = 1'b0;
    w[ST_RD]          = !j.wr && !j.quad;
    w[ST_WR]          =  j.wr && !j.quad;
    w[ST_QRD]         = !j.wr &&  j.quad;
    w[ST_QWR]         =  j.wr &&  j.quad;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_job_apb_port.sv
`default_nettype none
// ============================================================================
// Module   : spi_job_apb_port
// Purpose  : Single-transfer APB master. A level request launches a SETUP
//            cycle; ACCESS is held until PREADY, when ack pulses for one
//            cycle together with rdata/err. The port idles one cycle after
//            each completion so the requester can present the next transfer.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            req/req_write/req_addr/req_wdata - transfer request
//            ack/rdata/err      - completion strobe, read data, slave error
//            P*                 - APB master signals
// Revision : 1.0 - initial release
// ============================================================================
module spi_job_apb_port #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      ack,
  output logic [31:0]               rdata,
  output logic                      err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [31:0]               r_pwdata;

  // Address, data and direction are captured at launch so they stay
  // stable through SETUP and ACCESS regardless of requester changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (!r_psel) begin
      if (req) begin
        r_psel   <= 1'b1;
        r_pwrite <= req_write;
        r_paddr  <= req_addr;
        r_pwdata <= req_wdata;
      end
    end else if (!r_penable) begin
      r_penable <= 1'b1;
    end else if (PREADY) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign ack     = r_psel && r_penable && PREADY;
  assign rdata   = PRDATA;
  assign err     = ack && PSLVERR;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PWRITE  = r_pwrite;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;

endmodule
`default_nettype wire

// File: rtl/spi_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_job_sequencer
// Purpose  : Autonomous APB master running one complete SPI transfer on the
//            SPI master register block: programs CMD/ADDR/LEN/DUMMY, starts
//            the transfer, streams TX words in or RX words out, polls STATUS
//            until idle, then pulses done.
// Ports    : HCLK, HRESET                   - clock, sync active-high reset
//            job_*                          - job descriptor, valid/ready
//            tx_data_i/tx_valid_i/tx_ready_o - write-data stream
//            rx_data_o/rx_valid_o/rx_ready_i - read-data stream
//            done_o, busy_o, err_o          - status (err_o sticky per job)
//            P*                             - APB master port
// Revision : 1.0 - initial release
// ============================================================================
module spi_job_sequencer
  import spi_job_seq_pkg::*;
#(
  parameter int                      APB_ADDR_WIDTH = 12,
  parameter logic [APB_ADDR_WIDTH-1:0] SPI_BASE     = '0,
  parameter int                      BUFFER_DEPTH   = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [31:0]               job_cmd_i,
  input  logic [5:0]                job_cmd_len_i,
  input  logic [31:0]               job_addr_i,
  input  logic [5:0]                job_addr_len_i,
  input  logic [15:0]               job_dummy_i,
  input  logic [15:0]               job_data_len_i,
  input  logic                      job_wr_i,
  input  logic                      job_quad_i,
  input  logic [1:0]                job_cs_i,
  input  logic [31:0]               tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [31:0]               rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      done_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      err_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  job_t        r_job;
  logic [16:0] r_words;
  logic [31:0] r_rx_data;
  logic        r_err;

  logic        w_req;
  logic        w_req_write;
  logic [7:0]  w_off;
  logic [31:0] w_wdata;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_err;

  logic        w_accept;
  logic [16:0] w_words;
  logic        w_etx_ok;
  logic        w_erx_any;
  logic        w_last_word;
  logic        w_word_done;
  logic        w_unused_status;

  assign w_accept  = (r_state == S_IDLE) && job_valid_i;
  // Number of 32-bit words, rounded up; 17 bits so 0xFFFF+31 cannot wrap
  assign w_words   = ({1'b0, job_data_len_i} + 17'd31) >> 5;
  assign w_etx_ok  = 32'(w_rdata[ST_ETX_LSB +: 8]) < 32'(BUFFER_DEPTH);
  assign w_erx_any = |w_rdata[ST_ERX_LSB +: 8];
  assign w_last_word = (r_words == 17'd1);
  assign w_word_done = ((r_state == S_WR_DATA) && w_ack) ||
                       ((r_state == S_RX_HOLD) && rx_ready_i);
  assign w_unused_status = ^w_rdata[15:1];

  spi_job_apb_port #(
    .APB_ADDR_WIDTH(APB_ADDR_WIDTH)
  ) u_apb (
    .clk      (HCLK),
    .rst      (HRESET),
    .req      (w_req),
    .req_write(w_req_write),
    .req_addr (SPI_BASE + APB_ADDR_WIDTH'(w_off)),
    .req_wdata(w_wdata),
    .ack      (w_ack),
    .rdata    (w_rdata),
    .err      (w_err),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_job     <= '0;
      r_words   <= '0;
      r_rx_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_job.cmd      <= job_cmd_i;
        r_job.cmd_len  <= job_cmd_len_i;
        r_job.addr     <= job_addr_i;
        r_job.addr_len <= job_addr_len_i;
        r_job.dummy    <= job_dummy_i;
        r_job.data_len <= job_data_len_i;
        r_job.wr       <= job_wr_i;
        r_job.quad     <= job_quad_i;
        r_job.cs       <= job_cs_i;
        r_words        <= w_words;
        r_err          <= 1'b0;
      end else begin
        if (w_word_done) r_words <= r_words - 17'd1;
        if (w_err)       r_err   <= 1'b1;
      end
      if ((r_state == S_RD_DATA) && w_ack) r_rx_data <= w_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_req_write = 1'b0;
    w_off       = REG_STATUS;
    w_wdata     = '0;
    unique case (r_state)
      S_IDLE: begin
        if (job_valid_i) w_state_nxt = S_W_CMD;
      end
      S_W_CMD: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_CMD; w_wdata = r_job.cmd;
        if (w_ack) w_state_nxt = S_W_ADDR;
      end
      S_W_ADDR: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_ADDR; w_wdata = r_job.addr;
        if (w_ack) w_state_nxt = S_W_LEN;
      end
      S_W_LEN: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_LEN; w_wdata = len_word(r_job);
        if (w_ack) w_state_nxt = S_W_DUM;
      end
      S_W_DUM: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_DUMMY; w_wdata = dummy_word(r_job);
        if (w_ack) w_state_nxt = S_W_START;
      end
      S_W_START: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_STATUS;
        w_wdata = status_start_word(r_job);
        if (w_ack) begin
          if (r_words == 17'd0) w_state_nxt = S_POLL_IDLE;
          else if (r_job.wr)    w_state_nxt = S_WR_POLL;
          else                  w_state_nxt = S_RD_POLL;
        end
      end
      // Staying in a poll state re-issues the STATUS read
      S_WR_POLL: begin
        w_req = 1'b1; w_off = REG_STATUS;
        if (w_ack && w_etx_ok && tx_valid_i) w_state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        w_req = 1'b1; w_req_write = 1'b1; w_off = REG_TXFIFO; w_wdata = tx_data_i;
        if (w_ack) w_state_nxt = w_last_word ? S_POLL_IDLE : S_WR_POLL;
      end
      S_RD_POLL: begin
        w_req = 1'b1; w_off = REG_STATUS;
        if (w_ack && w_erx_any) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_req = 1'b1; w_off = REG_RXFIFO;
        if (w_ack) w_state_nxt = S_RX_HOLD;
      end
      // No request here: RX backpressure stalls all APB traffic
      S_RX_HOLD: begin
        if (rx_ready_i) w_state_nxt = w_last_word ? S_POLL_IDLE : S_RD_POLL;
      end
      S_POLL_IDLE: begin
        w_req = 1'b1; w_off = REG_STATUS;
        if (w_ack && w_rdata[ST_IDLE]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign job_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign tx_ready_o  = (r_state == S_WR_DATA) && w_ack;
  assign rx_valid_o  = (r_state == S_RX_HOLD);
  assign rx_data_o   = r_rx_data;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_job_sequencer
// Purpose  : Self-checking bench for spi_job_sequencer with a scripted APB
//            slave standing in for the SPI master register block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_job_sequencer;

  logic        HCLK;
  logic        HRESET;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [31:0] job_cmd_i;
  logic [5:0]  job_cmd_len_i;
  logic [31:0] job_addr_i;
  logic [5:0]  job_addr_len_i;
  logic [15:0] job_dummy_i;
  logic [15:0] job_data_len_i;
  logic        job_wr_i;
  logic        job_quad_i;
  logic [1:0]  job_cs_i;
  logic [31:0] tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        done_o;
  logic        busy_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        err_o;

  spi_job_sequencer #(
    .APB_ADDR_WIDTH(12),
    .SPI_BASE      (12'h000),
    .BUFFER_DEPTH  (8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_cmd_i(job_cmd_i), .job_cmd_len_i(job_cmd_len_i),
    .job_addr_i(job_addr_i), .job_addr_len_i(job_addr_len_i),
    .job_dummy_i(job_dummy_i), .job_data_len_i(job_data_len_i),
    .job_wr_i(job_wr_i), .job_quad_i(job_quad_i), .job_cs_i(job_cs_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .done_o(done_o), .busy_o(busy_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .err_o(err_o)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // ---------------- scripted slave controls (driven by the stimulus) -------
  int len_waits  = 0;
  logic err_len  = 1'b0;
  int full_base  = 0, full_polls = 0;
  int busy_base  = 0, busy_polls = 0;
  int rx_base    = 0, rx_empty   = 0;

  // ---------------- monitor state ----------------
  int n_total = 0, n_bad = 0;
  int acc_cnt = 0, status_rd_cnt = 0, rd_idx = 0, tx_cnt = 0, len_acc = 0;
  int log_n = 0, rx_n = 0, done_cnt = 0, done_wide = 0, psel_cyc = 0;
  int stab_bad = 0, txr_bad = 0;
  logic        done_q = 1'b0;
  logic [11:0] s_addr;
  logic [31:0] s_data;
  logic        s_wr;
  logic [11:0] log_a [0:255];
  logic        log_w [0:255];
  logic [31:0] log_d [0:255];
  logic [31:0] rx_log [0:63];

  int   waits_now;
  logic st_idle, tx_full_now, rx_empty_now, txfifo_done;

  assign tx_full_now  = (status_rd_cnt - full_base) < full_polls;
  assign rx_empty_now = (status_rd_cnt - rx_base) < rx_empty;
  assign st_idle      = (status_rd_cnt - busy_base) >= busy_polls;
  assign txfifo_done  = PSEL && PENABLE && PREADY && PWRITE && (PADDR == 12'h018);
  // Source data advances once per accepted TX word
  assign tx_data_i    = 32'hD0D0_0000 + 32'(tx_cnt);

  always_comb begin
    waits_now = (PSEL && PWRITE && PADDR == 12'h010) ? len_waits : 0;
    PREADY    = PSEL && PENABLE && (acc_cnt >= waits_now);
    PSLVERR   = PREADY && PWRITE && (PADDR == 12'h010) && err_len;
    PRDATA    = 32'h0;
    if (PSEL && !PWRITE) begin
      if (PADDR == 12'h000)
        PRDATA = {tx_full_now ? 8'd8 : 8'd7, rx_empty_now ? 8'd0 : 8'd2,
                  9'd0, st_idle ? 7'h01 : 7'h04};
      else if (PADDR == 12'h020)
        PRDATA = 32'hCAFE_0000 + 32'(rd_idx);
    end
  end

  always @(posedge HCLK) begin
    done_q <= done_o;
    if (done_o) done_cnt <= done_cnt + 1;
    if (done_o && done_q) done_wide <= done_wide + 1;
    if (PSEL) psel_cyc <= psel_cyc + 1;
    if (rx_valid_o && rx_ready_i) begin
      if (rx_n < 64) rx_log[rx_n] <= rx_data_o;
      rx_n <= rx_n + 1;
    end
    if (tx_ready_o) tx_cnt <= tx_cnt + 1;
    if ((tx_ready_o != txfifo_done) || (tx_ready_o && tx_full_now)) txr_bad <= txr_bad + 1;
    if (PSEL && !PENABLE) begin
      s_addr  <= PADDR;
      s_data  <= PWDATA;
      s_wr    <= PWRITE;
      acc_cnt <= 0;
    end else if (PSEL && PENABLE) begin
      if (PADDR !== s_addr || PWDATA !== s_data || PWRITE !== s_wr) stab_bad <= stab_bad + 1;
      if (PREADY) begin
        acc_cnt <= 0;
        if (log_n < 256) begin
          log_a[log_n] <= PADDR;
          log_w[log_n] <= PWRITE;
          log_d[log_n] <= PWRITE ? PWDATA : PRDATA;
        end
        log_n <= log_n + 1;
        if (!PWRITE && PADDR == 12'h000) status_rd_cnt <= status_rd_cnt + 1;
        if (!PWRITE && PADDR == 12'h020) rd_idx <= rd_idx + 1;
        if (PWRITE && PADDR == 12'h010) len_acc <= acc_cnt + 1;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      if (PENABLE) stab_bad <= stab_bad + 1;
      acc_cnt <= 0;
    end
  end

  // ---------------- checking and stimulus helpers ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string t, input int i, input logic [11:0] a,
                           input logic w, input logic [31:0] d);
    if (i < 256) begin
      check_val({t, ".a"}, {19'd0, log_w[i], log_a[i]}, {19'd0, w, a});
      if (w) check_val({t, ".d"}, log_d[i], d);
    end else begin
      check_val({t, ".idx"}, i, 0);
    end
  endtask

  task automatic check_cfg(input string t, input int b, input logic [31:0] cmd,
                           input logic [31:0] ad, input logic [31:0] ln,
                           input logic [31:0] dm, input logic [31:0] st);
    check_log({t, ".cmd"}, b,     12'h008, 1'b1, cmd);
    check_log({t, ".adr"}, b + 1, 12'h00C, 1'b1, ad);
    check_log({t, ".len"}, b + 2, 12'h010, 1'b1, ln);
    check_log({t, ".dum"}, b + 3, 12'h014, 1'b1, dm);
    check_log({t, ".sta"}, b + 4, 12'h000, 1'b1, st);
  endtask

  task automatic start_job(input logic [31:0] cmd, input logic [5:0] cl,
                           input logic [31:0] ad, input logic [5:0] al,
                           input logic [15:0] dm, input logic [15:0] dl,
                           input logic wr, input logic quad, input logic [1:0] cs);
    @(negedge HCLK);
    check_val("job_ready", {31'd0, job_ready_o}, 32'd1);
    job_cmd_i = cmd; job_cmd_len_i = cl; job_addr_i = ad; job_addr_len_i = al;
    job_dummy_i = dm; job_data_len_i = dl; job_wr_i = wr; job_quad_i = quad;
    job_cs_i = cs; job_valid_i = 1'b1;
    @(negedge HCLK);
    job_valid_i = 1'b0;
    check_val("busy", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic wait_done(input string t, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge HCLK);
      k++;
    end
    @(negedge HCLK);
    @(negedge HCLK);
    check_val(t, done_cnt - d0, 32'd1);
  endtask

  initial begin
    int b, d0, t0, r0, p0, k, unstable, fifo_acc;
    logic [31:0] hold;

    HRESET = 1'b1; job_valid_i = 1'b0; job_cmd_i = '0; job_cmd_len_i = '0;
    job_addr_i = '0; job_addr_len_i = '0; job_dummy_i = '0; job_data_len_i = '0;
    job_wr_i = 1'b0; job_quad_i = 1'b0; job_cs_i = '0;
    tx_valid_i = 1'b1; rx_ready_i = 1'b1;
    repeat (3) @(negedge HCLK);
    check_val("rst.outs", {24'd0, job_ready_o, busy_o, done_o, PSEL, PENABLE,
                           err_o, rx_valid_o, tx_ready_o}, 32'h80);
    HRESET = 1'b0;

    // Test 1: quad read job, 2 words
    b = log_n; d0 = done_cnt; r0 = rx_n;
    start_job(32'hEB00_0000, 6'd8, 32'h1234_5600, 6'd24, 16'd8, 16'd64, 1'b0, 1'b1, 2'd0);
    wait_done("t1.done", d0);
    check_cfg("t1", b, 32'hEB00_0000, 32'h1234_5600, 32'h0040_1808, 32'h0000_0008, 32'h0000_0104);
    check_log("t1.p0", b + 5, 12'h000, 1'b0, 32'h0);
    check_log("t1.r0", b + 6, 12'h020, 1'b0, 32'h0);
    check_log("t1.p1", b + 7, 12'h000, 1'b0, 32'h0);
    check_log("t1.r1", b + 8, 12'h020, 1'b0, 32'h0);
    check_log("t1.pi", b + 9, 12'h000, 1'b0, 32'h0);
    check_val("t1.n", log_n - b, 32'd10);
    check_val("t1.rxn", rx_n - r0, 32'd2);
    check_val("t1.rx0", rx_log[r0], 32'hCAFE_0000);
    check_val("t1.rx1", rx_log[r0 + 1], 32'hCAFE_0001);

    // Test 2: write job, 3 words, cs=2
    b = log_n; d0 = done_cnt; t0 = tx_cnt;
    start_job(32'h0200_0000, 6'd8, 32'h0001_0000, 6'd24, 16'd0, 16'd96, 1'b1, 1'b0, 2'd2);
    wait_done("t2.done", d0);
    check_cfg("t2", b, 32'h0200_0000, 32'h0001_0000, 32'h0060_1808, 32'h0000_0000, 32'h0000_0402);
    for (int i = 0; i < 3; i++) begin
      check_log("t2.poll", b + 5 + 2 * i, 12'h000, 1'b0, 32'h0);
      check_log("t2.tx",   b + 6 + 2 * i, 12'h018, 1'b1, 32'hD0D0_0000 + 32'(t0 + i));
    end
    check_log("t2.pi", b + 11, 12'h000, 1'b0, 32'h0);
    check_val("t2.n", log_n - b, 32'd12);
    check_val("t2.txn", tx_cnt - t0, 32'd3);

    // Test 3: TX FIFO full for 5 polls, 1 word, cs=1
    full_base = status_rd_cnt; full_polls = 5;
    b = log_n; d0 = done_cnt; t0 = tx_cnt;
    start_job(32'h0300_0000, 6'd8, 32'h0002_0000, 6'd24, 16'd2, 16'd32, 1'b1, 1'b0, 2'd1);
    wait_done("t3.done", d0);
    check_cfg("t3", b, 32'h0300_0000, 32'h0002_0000, 32'h0020_1808, 32'h0002_0000, 32'h0000_0202);
    for (int i = 0; i < 6; i++) check_log("t3.poll", b + 5 + i, 12'h000, 1'b0, 32'h0);
    check_log("t3.tx", b + 11, 12'h018, 1'b1, 32'hD0D0_0000 + 32'(t0));
    check_log("t3.pi", b + 12, 12'h000, 1'b0, 32'h0);
    check_val("t3.n", log_n - b, 32'd13);
    check_val("t3.txr", txr_bad, 32'd0);
    full_polls = 0;

    // Test 4: RX empty for 2 polls, then backpressure for 10 cycles, cs=3
    rx_base = status_rd_cnt; rx_empty = 2; rx_ready_i = 1'b0;
    b = log_n; d0 = done_cnt; r0 = rx_n;
    start_job(32'h0B00_0000, 6'd8, 32'h0003_0000, 6'd24, 16'd4, 16'd32, 1'b0, 1'b0, 2'd3);
    k = 0;
    while (!rx_valid_o && k < 500) begin
      @(negedge HCLK);
      k++;
    end
    check_val("t4.rxv", {31'd0, rx_valid_o}, 32'd1);
    check_val("t4.rxd", rx_data_o, 32'hCAFE_0002);
    hold = rx_data_o; p0 = psel_cyc; unstable = 0;
    repeat (10) begin
      @(negedge HCLK);
      if (rx_data_o !== hold || !rx_valid_o) unstable++;
    end
    check_val("t4.stable", unstable, 32'd0);
    check_val("t4.apb_idle", psel_cyc - p0, 32'd0);
    rx_ready_i = 1'b1;
    wait_done("t4.done", d0);
    check_cfg("t4", b, 32'h0B00_0000, 32'h0003_0000, 32'h0020_1808, 32'h0000_0004, 32'h0000_0801);
    for (int i = 0; i < 3; i++) check_log("t4.poll", b + 5 + i, 12'h000, 1'b0, 32'h0);
    check_log("t4.rd", b + 8, 12'h020, 1'b0, 32'h0);
    check_log("t4.pi", b + 9, 12'h000, 1'b0, 32'h0);
    check_val("t4.n", log_n - b, 32'd10);
    check_val("t4.rxn", rx_n - r0, 32'd1);
    check_val("t4.rx0", rx_log[r0], 32'hCAFE_0002);
    rx_empty = 0;

    // Test 5: 3 wait states plus slave error on LEN, quad write, data_len=0
    check_val("t5.err0", {31'd0, err_o}, 32'd0);
    len_waits = 3; err_len = 1'b1;
    b = log_n; d0 = done_cnt;
    start_job(32'h3800_0000, 6'd8, 32'h0004_0000, 6'd24, 16'd6, 16'd0, 1'b1, 1'b1, 2'd0);
    wait_done("t5.done", d0);
    check_cfg("t5", b, 32'h3800_0000, 32'h0004_0000, 32'h0000_1808, 32'h0006_0000, 32'h0000_0108);
    check_val("t5.penable", len_acc, 32'd4);
    check_val("t5.err", {31'd0, err_o}, 32'd1);
    check_val("t5.n", log_n - b, 32'd6);
    len_waits = 0; err_len = 1'b0;

    // Test 6: data_len=0 read, 3 busy polls; err_o clears on accept
    busy_base = status_rd_cnt; busy_polls = 3;
    b = log_n; d0 = done_cnt;
    start_job(32'h0500_0000, 6'd8, 32'h0005_0000, 6'd24, 16'd10, 16'd0, 1'b0, 1'b0, 2'd0);
    check_val("t6.errclr", {31'd0, err_o}, 32'd0);
    wait_done("t6.done", d0);
    check_cfg("t6", b, 32'h0500_0000, 32'h0005_0000, 32'h0000_1808, 32'h0000_000A, 32'h0000_0101);
    for (int i = 0; i < 4; i++) check_log("t6.poll", b + 5 + i, 12'h000, 1'b0, 32'h0);
    check_val("t6.n", log_n - b, 32'd9);
    fifo_acc = 0;
    for (int i = b; i < log_n && i < 256; i++)
      if (log_a[i] == 12'h018 || log_a[i] == 12'h020) fifo_acc++;
    check_val("t6.nofifo", fifo_acc, 32'd0);

    // Test 7: reset while polling STATUS
    busy_base = status_rd_cnt; busy_polls = 100000;
    b = log_n;
    start_job(32'h0600_0000, 6'd8, 32'h0006_0000, 6'd24, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0);
    k = 0;
    while (log_n < b + 6 && k < 500) begin
      @(negedge HCLK);
      k++;
    end
    check_val("t7.reach", {31'd0, (log_n >= b + 6)}, 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    check_val("t7.psel", {30'd0, PSEL, PENABLE}, 32'd0);
    check_val("t7.ready", {30'd0, job_ready_o, busy_o}, 32'd2);
    HRESET = 1'b0;
    busy_polls = 0;
    repeat (3) @(negedge HCLK);

    check_val("done.width", done_wide, 32'd0);
    check_val("apb.stable", stab_bad, 32'd0);
    check_val("tx.ready", txr_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
